// File: rtl/uart8_pkg.sv
// Shared UART definitions: FSM state type, data width and bit-period helper.
package uart8_pkg;

  localparam int unsigned UART8_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart8_state_e;

  // Clock cycles per bit, truncated toward zero.
  function automatic int unsigned uart8_bit_period(input int unsigned clock_rate,
                                                   input int unsigned baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart8_transmitter_if.sv
// Byte handshake and serial line between a frame source and the UART transmitter.
interface uart8_transmitter_if;
  import uart8_pkg::*;

  logic                       txEn;
  logic                       txStart;
  logic [UART8_DATA_BITS-1:0] in;
  logic                       txBusy;
  logic                       txDone;
  logic                       tx;

  modport master (
    output txEn, txStart, in,
    input  txBusy, txDone, tx
  );

  modport slave (
    input  txEn, txStart, in,
    output txBusy, txDone, tx
  );

endinterface

// File: rtl/uart8_baud_tick.sv
// Bit-period timer: counts 0..PERIOD-1 and flags the last count with a registered tick.
module uart8_baud_tick #(
  parameter int unsigned PERIOD = 1250
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned      CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // Next count: held at zero while cleared, otherwise wraps after LAST.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
    tick_d = (count_d == LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart8_transmitter.sv
// 8-bit UART transmitter: start bit, eight data bits LSB first, stop bit.
// Define UART8_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart8_transmitter
  import uart8_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 12000000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input logic               clk,
  input logic               reset,
  uart8_transmitter_if.slave bus
);

  localparam int unsigned D = uart8_bit_period(CLOCK_RATE, BAUD_RATE);
  localparam int unsigned W = UART8_DATA_BITS;

  localparam logic [2:0] IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] START  = 3'(ST_START);
  localparam logic [2:0] DATA   = 3'(ST_DATA);
`ifdef UART8_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'(ST_PARITY);
`endif
  localparam logic [2:0] STOP   = 3'(ST_STOP);

  localparam logic [2:0] LAST_IDX = 3'(W - 1);

  logic [2:0]   state_q, state_d;
  logic [W-1:0] shift_q, shift_d;
  logic [2:0]   idx_q,   idx_d;
  logic         tx_q,    tx_d;
  logic         busy_q,  busy_d;
  logic         done_q,  done_d;
`ifdef UART8_TX_PARITY_EN
  logic         par_q,   par_d;
`endif

  logic tick;
  logic baud_clear_c;

  // Bit timer is held cleared while idle so each frame starts on a fresh period.
  assign baud_clear_c = (state_q == IDLE);

  uart8_baud_tick #(
    .PERIOD (D)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear_c),
    .tick  (tick)
  );

  // Frame sequencing and next values of the registered line outputs.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART8_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.txEn && bus.txStart) begin
          shift_d = bus.in;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
`ifdef UART8_TX_PARITY_EN
          par_d   = ^bus.in;
`endif
        end
      end
      START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
`ifdef UART8_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[W-1:1]};
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART8_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART8_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART8_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.tx     = tx_q;
  assign bus.txBusy = busy_q;
  assign bus.txDone = done_q;

endmodule

// File: tb/tb_uart8_transmitter.sv
// Testbench for uart8_transmitter: default-rate instance plus a fast instance (D=14).
module tb_uart8_transmitter;

  localparam int DD = 1250;   // 12000000 / 9600
  localparam int DF = 14;     // 100 / 7, truncated
`ifdef UART8_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef logic [0:NB-1] seq_t;   // serial bits in line order
  typedef struct {
    logic [7:0] data;
    seq_t       seq;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart8_transmitter_if d_if ();
  uart8_transmitter_if f_if ();

  uart8_transmitter dut_def (
    .clk   (clk),
    .reset (reset),
    .bus   (d_if.slave)
  );

  uart8_transmitter #(
    .CLOCK_RATE (100),
    .BAUD_RATE  (7)
  ) dut_f (
    .clk   (clk),
    .reset (reset),
    .bus   (f_if.slave)
  );

  int   tests = 0;
  int   fails = 0;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line level for serial bit b of a frame carrying d.
  function automatic logic model_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART8_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Reference model for the fast instance: frame timing from the accepting edge.
  int         m_cyc = 0;
  bit         m_act = 1'b0;
  int         m_e0  = 0;
  logic [7:0] m_data;
  always @(posedge clk) begin : mon_blk
    logic       r, en, st;
    logic [7:0] din;
    logic [2:0] exp;
    int         k;
    r   = reset;
    en  = f_if.txEn;
    st  = f_if.txStart;
    din = f_if.in;
    if (r) begin
      m_act = 1'b0;
      exp   = 3'b100;
    end else if (m_act) begin
      k = m_cyc - m_e0;
      if (k < NB * DF) begin
        exp = {model_bit(m_data, k / DF), 1'b1, 1'b0};
      end else begin
        exp   = 3'b101;
        m_act = 1'b0;
      end
    end else if (en && st) begin
      m_act  = 1'b1;
      m_e0   = m_cyc;
      m_data = din;
      exp    = 3'b010;
    end else begin
      exp = 3'b100;
    end
    m_cyc++;
    #1;
    chk($sformatf("model cyc%0d", m_cyc - 1),
        32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'(exp));
  end

  // One frame on the default instance, with a re-pulse of txStart mid-frame.
  task automatic def_test();
    int dcnt = 0;
    d_if.txEn    = 1'b1;
    d_if.txStart = 1'b1;
    d_if.in      = 8'hB5;
    for (int k = 0; k <= NB * DD + 3; k++) begin
      @(posedge clk); #1;
      if (k < NB * DD) begin
        if ((k % DD == 0) || (k % DD == DD / 2) || (k % DD == DD - 1))
          chk($sformatf("def bit%0d k%0d", k / DD, k),
              32'({d_if.tx, d_if.txBusy, d_if.txDone}), 32'({vecs[0].seq[k / DD], 2'b10}));
      end else if (k == NB * DD) begin
        chk("def done", 32'({d_if.tx, d_if.txBusy, d_if.txDone}), 32'(3'b101));
      end else begin
        chk($sformatf("def idle k%0d", k), 32'({d_if.tx, d_if.txBusy, d_if.txDone}), 32'(3'b100));
      end
      if (d_if.txDone) dcnt++;
      #1;
      if (k == 0) d_if.txStart = 1'b0;
      if (k == 2999) begin
        d_if.txStart = 1'b1;
        d_if.in      = 8'h00;
      end
      if (k == 3002) d_if.txStart = 1'b0;
    end
    chk("def done count", 32'(dcnt), 32'd1);
  endtask

  // Single frame on the fast instance checked every cycle against a table row.
  task automatic send_f(input int vi);
    f_if.txEn    = 1'b1;
    f_if.txStart = 1'b1;
    f_if.in      = vecs[vi].data;
    for (int k = 0; k <= NB * DF; k++) begin
      @(posedge clk); #1;
      if (k < NB * DF)
        chk($sformatf("vec%0d k%0d", vi, k),
            32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'({vecs[vi].seq[k / DF], 2'b10}));
      else
        chk($sformatf("vec%0d done", vi), 32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'(3'b101));
      #1;
      if (k == 0) begin
        f_if.txStart = 1'b0;
        f_if.in      = ~vecs[vi].data;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    reset        = 1'b1;
    d_if.txEn    = 1'b0;
    d_if.txStart = 1'b0;
    d_if.in      = 8'h00;
    f_if.txEn    = 1'b0;
    f_if.txStart = 1'b0;
    f_if.in      = 8'h00;

`ifdef UART8_TX_PARITY_EN
    vecs[0] = '{8'hB5, 11'b0_10101101_1_1};
    vecs[1] = '{8'h3C, 11'b0_00111100_0_1};
    vecs[2] = '{8'h00, 11'b0_00000000_0_1};
    vecs[3] = '{8'hFF, 11'b0_11111111_0_1};
    vecs[4] = '{8'h03, 11'b0_11000000_0_1};
    vecs[5] = '{8'h80, 11'b0_00000001_1_1};
`else
    vecs[0] = '{8'hB5, 10'b0_10101101_1};
    vecs[1] = '{8'h3C, 10'b0_00111100_1};
    vecs[2] = '{8'h00, 10'b0_00000000_1};
    vecs[3] = '{8'hFF, 10'b0_11111111_1};
    vecs[4] = '{8'h03, 10'b0_11000000_1};
    vecs[5] = '{8'h80, 10'b0_00000001_1};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset def", 32'({d_if.tx, d_if.txBusy, d_if.txDone}), 32'(3'b100));
    chk("reset fast", 32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'(3'b100));
    #1;
    reset = 1'b0;

    def_test();

    for (int i = 0; i < 6; i++) send_f(i);
    idle_cycles(5);

    // Disabled: txStart held high must never start a frame.
    f_if.txEn    = 1'b0;
    f_if.txStart = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (c % 100 == 99)
        chk($sformatf("disabled c%0d", c), 32'({f_if.tx, f_if.txBusy}), 32'(2'b10));
      #1;
      f_if.in = 8'($urandom);
    end

    // txEn dropped mid-frame: frame completes, no restart afterwards.
    f_if.txEn    = 1'b1;
    f_if.txStart = 1'b1;
    f_if.in      = 8'hB5;
    for (int k = 0; k <= NB * DF + 200; k++) begin
      @(posedge clk); #1;
      if (k < NB * DF)
        chk($sformatf("endrop k%0d", k),
            32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'({vecs[0].seq[k / DF], 2'b10}));
      else if (k == NB * DF)
        chk("endrop done", 32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'(3'b101));
      else if (k % 20 == 0)
        chk($sformatf("endrop idle k%0d", k), 32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'(3'b100));
      #1;
      if (k == 20) f_if.txEn = 1'b0;
    end
    f_if.txStart = 1'b0;
    f_if.txEn    = 1'b1;
    idle_cycles(3);

    // Reset mid-frame: line returns high at once and no completion follows.
    f_if.txStart = 1'b1;
    f_if.in      = 8'h3C;
    for (int k = 0; k <= NB * DF + 20; k++) begin
      @(posedge clk); #1;
      if (k < 60)
        chk($sformatf("rst pre k%0d", k),
            32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'({vecs[1].seq[k / DF], 2'b10}));
      else
        chk($sformatf("rst post k%0d", k), 32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'(3'b100));
      #1;
      if (k == 0)  f_if.txStart = 1'b0;
      if (k == 59) reset = 1'b1;
      if (k == 60) reset = 1'b0;
    end
    send_f(1);
    idle_cycles(2);

    // txStart held high: two frames separated by exactly one idle-high cycle.
    f_if.txStart = 1'b1;
    f_if.in      = 8'hB5;
    for (int k = 0; k <= 2 * NB * DF + 1; k++) begin
      @(posedge clk); #1;
      if (k < NB * DF)
        chk($sformatf("b2b f0 k%0d", k),
            32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'({vecs[0].seq[k / DF], 2'b10}));
      else if (k == NB * DF)
        chk("b2b gap", 32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'(3'b101));
      else if (k - (NB * DF + 1) < NB * DF)
        chk($sformatf("b2b f1 k%0d", k),
            32'({f_if.tx, f_if.txBusy, f_if.txDone}),
            32'({vecs[1].seq[(k - (NB * DF + 1)) / DF], 2'b10}));
      else
        chk("b2b f1 done", 32'({f_if.tx, f_if.txBusy, f_if.txDone}), 32'(3'b101));
      #1;
      if (k == 0)           f_if.in      = 8'h3C;
      if (k == NB * DF + 1) f_if.txStart = 1'b0;
    end
    idle_cycles(2);

    // Random traffic, checked by the reference model every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      f_if.txEn    = ($urandom_range(0, 9) != 0);
      f_if.txStart = ($urandom_range(0, 3) == 0);
      f_if.in      = 8'($urandom);
      reset        = ($urandom_range(0, 499) == 0);
    end
    reset        = 1'b0;
    f_if.txStart = 1'b0;
    idle_cycles(NB * DF + 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
